priority_resolver_isr: RTL and testbench
========================================

// Module: priority_resolver_isr
// PURPOSE
//  Stage directly downstream of Interrupt_Mask: resolves priority among masked requests
//  (irq), owns the In-Service Register (ISR), and runs the 8259A INTA two-pulse handshake.
//  Drives intOut to the CPU, returns one-shot clear pulses to the IRR, and returns the
//  vector byte. Handles EOI (specific/non-specific), AEOI and rotate-on-EOI.
// PARAMETERS
//  RESET_LOWEST  3'd7  lowestPriority pointer value after reset (IR0 highest)
//  SPURIOUS_LVL  3'd7  level reported when the request vanishes before the first INTA
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  irq            in   8  masked requests from Interrupt_Mask, level, bit n = IRn
//  vectorBase     in   5  ICW2 bits T7..T3
//  aeoiMode       in   1  1 = automatic EOI at end of 2nd INTA pulse
//  rotateOnEoi    in   1  1 = level cleared by any EOI becomes lowest priority
//  eoiValid       in   1  one-cycle EOI command strobe
//  eoiSpecific    in   1  1 = clear eoiLevel; 0 = clear highest-priority ISR bit
//  eoiLevel       in   3  level for specific EOI
//  inta_n         in   1  CPU acknowledge, active-low, synchronous to clk
//  intOut         out  1  interrupt request to CPU
//  clrIrr         out  8  one-hot, one-cycle pulse: clear this IRR bit
//  isr            out  8  In-Service Register
//  vectorOut      out  8  {vectorBase, level} during 2nd INTA
//  vectorValid    out  1  vectorOut is valid (drive data bus)
// BEHAVIOUR
//  Reset (async): intOut=0, clrIrr=0, isr=0, vectorOut=0, vectorValid=0, state=IDLE,
//   lowestPriority=RESET_LOWEST, intaPrev=1. Reset mid-handshake aborts with no ISR change.
//  Priority: rank of level L = (L - lowestPriority - 1) mod 8; rank 0 highest.
//  Winner = highest-ranked set bit of irq. Qualifies if isr==0 or winner outranks the
//   highest-ranked set isr bit (fully nested; equal or lower rank blocked).
//  inta fall = intaPrev & ~inta_n; inta rise = ~intaPrev & inta_n; intaPrev <= inta_n.
//  All outputs registered; every action is visible the cycle after the edge is sampled.
//  FSM:
//   IDLE: intOut <= qualifies. Fall with intOut=1 -> if still qualifies: isr[w]<=1,
//    clrIrr<=onehot(w), level<=w; else level<=SPURIOUS_LVL, no isr/clrIrr change.
//    intOut<=0, go ACK1. Fall with intOut=0: ignored.
//   ACK1: intOut=0. Next fall -> vectorOut<={vectorBase,level}, vectorValid<=1, go ACK2.
//   ACK2: hold vectorOut/vectorValid while inta_n low. Rise -> vectorValid<=0; if
//    aeoiMode and not spurious: clear isr[level], rotate if rotateOnEoi. Go IDLE.
//    Exactly one cycle later, intOut is re-evaluated in IDLE.
//  clrIrr is high exactly one cycle; 0 otherwise.
//  EOI (any state, eoiValid=1): non-specific clears highest-ranked set isr bit
//   (isr==0 -> no-op, no rotate); specific clears isr[eoiLevel] (bit already 0 -> still
//   rotates if rotateOnEoi). rotateOnEoi: lowestPriority <= cleared level.
//  Simultaneous events same cycle: EOI computed on pre-cycle isr/pointer; INTA set of the
//   same bit wins over EOI clear; AEOI rotation wins over EOI rotation.
//  Spurious levels never set or clear isr.
// TESTING
//  1 irq=0x04, isr=0, vectorBase=5'b01000 -> intOut=1 next cycle; INTA1 -> isr=0x04,
//    clrIrr=0x04 for 1 cycle, intOut=0; INTA2 -> vectorOut=0x42, vectorValid=1 until rise.
//  2 isr=0x04, irq=0x10 -> intOut stays 0; irq=0x12 -> intOut=1, winner IR1.
//  3 irq=0x08, drop to 0 before INTA1 -> isr unchanged, clrIrr=0, vectorOut={base,3'd7}.
//  4 isr=0x06, non-specific EOI, rotateOnEoi=1 -> isr=0x04, lowestPriority=1;
//    clear isr; irq=0x06 -> ack sets isr=0x04 (IR2 outranks IR1).
//  5 aeoiMode=1, full handshake for IR0 -> isr=0x01 during ACK1/ACK2, 0x00 after INTA2 rise.
//  6 rst_n low during ACK2 -> intOut=0, vectorValid=0, isr=0, lowestPriority=7 immediately.

Source files
------------

// File: rtl/priority_resolver_isr.sv
// 8259A-style priority resolver: ranks masked requests against the In-Service Register,
// runs the two-pulse INTA handshake and applies specific/non-specific/automatic EOI.
module priority_resolver_isr #(
  parameter logic [2:0] RESET_LOWEST = 3'd7,
  parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic [4:0] vectorBase,
  input  logic       aeoiMode,
  input  logic       rotateOnEoi,
  input  logic       eoiValid,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       inta_n,
  output logic       intOut,
  output logic [7:0] clrIrr,
  output logic [7:0] isr,
  output logic [7:0] vectorOut,
  output logic       vectorValid
);

  typedef enum logic [1:0] {StIdle, StAck1, StAck2} state_e;

  state_e     state_q;
  logic [2:0] lowest_q;
  logic [2:0] level_q;
  logic       spurious_q;
  logic       inta_prev_q;

  logic       inta_fall, inta_rise;
  logic       irq_any, isr_any, qualifies;
  logic [2:0] win, isr_top, win_rank, isr_rank;
  logic [7:0] win_onehot, level_onehot;
  logic [7:0] isr_eoi;
  logic [2:0] lowest_eoi;

  // Level holding priority rank r when lowest_q is the lowest-priority level.
  function automatic logic [2:0] level_at(input logic [2:0] low, input int r);
    return low + 3'(r) + 3'd1;
  endfunction

  assign inta_fall    = inta_prev_q & ~inta_n;
  assign inta_rise    = ~inta_prev_q & inta_n;
  assign win_onehot   = 8'b1 << win;
  assign level_onehot = 8'b1 << level_q;

  always_comb begin
    irq_any = 1'b0;
    win     = 3'd0;
    isr_any = 1'b0;
    isr_top = 3'd0;
    // Walk from lowest to highest rank so the last hit is the highest-ranked bit.
    for (int r = 7; r >= 0; r--) begin
      if (irq[level_at(lowest_q, r)]) begin
        irq_any = 1'b1;
        win     = level_at(lowest_q, r);
      end
      if (isr[level_at(lowest_q, r)]) begin
        isr_any = 1'b1;
        isr_top = level_at(lowest_q, r);
      end
    end
    win_rank  = win - lowest_q - 3'd1;
    isr_rank  = isr_top - lowest_q - 3'd1;
    qualifies = irq_any & (~isr_any | (win_rank < isr_rank));
  end

  // EOI effect on the pre-cycle ISR/pointer; the FSM may override it below.
  always_comb begin
    isr_eoi    = isr;
    lowest_eoi = lowest_q;
    if (eoiValid) begin
      if (eoiSpecific) begin
        isr_eoi[eoiLevel] = 1'b0;
        if (rotateOnEoi) lowest_eoi = eoiLevel;
      end else if (isr_any) begin
        isr_eoi[isr_top] = 1'b0;
        if (rotateOnEoi) lowest_eoi = isr_top;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lowest_q    <= RESET_LOWEST;
      level_q     <= 3'd0;
      spurious_q  <= 1'b0;
      inta_prev_q <= 1'b1;
      intOut      <= 1'b0;
      clrIrr      <= 8'd0;
      isr         <= 8'd0;
      vectorOut   <= 8'd0;
      vectorValid <= 1'b0;
    end else begin
      inta_prev_q <= inta_n;
      clrIrr      <= 8'd0;
      isr         <= isr_eoi;
      lowest_q    <= lowest_eoi;
      unique case (state_q)
        StIdle: begin
          intOut <= qualifies;
          if (inta_fall && intOut) begin
            intOut  <= 1'b0;
            state_q <= StAck1;
            if (qualifies) begin
              isr        <= isr_eoi | win_onehot;
              clrIrr     <= win_onehot;
              level_q    <= win;
              spurious_q <= 1'b0;
            end else begin
              level_q    <= SPURIOUS_LVL;
              spurious_q <= 1'b1;
            end
          end
        end
        StAck1: begin
          intOut <= 1'b0;
          if (inta_fall) begin
            vectorOut   <= {vectorBase, level_q};
            vectorValid <= 1'b1;
            state_q     <= StAck2;
          end
        end
        StAck2: begin
          intOut <= 1'b0;
          if (inta_rise) begin
            vectorValid <= 1'b0;
            state_q     <= StIdle;
            if (aeoiMode && !spurious_q) begin
              isr <= isr_eoi & ~level_onehot;
              if (rotateOnEoi) lowest_q <= level_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Scenario bench for priority_resolver_isr: expected vector bytes are queued when the
// second INTA pulse is driven and popped when vectorValid appears.
module tb_priority_resolver_isr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic [4:0] vectorBase;
  logic       aeoiMode, rotateOnEoi, eoiValid, eoiSpecific;
  logic [2:0] eoiLevel;
  logic       inta_n;
  logic       intOut;
  logic [7:0] clrIrr, isr, vectorOut;
  logic       vectorValid;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_vec[$];
  logic [7:0] exp_v;
  logic       got;

  priority_resolver_isr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .vectorBase (vectorBase),
    .aeoiMode   (aeoiMode),
    .rotateOnEoi(rotateOnEoi),
    .eoiValid   (eoiValid),
    .eoiSpecific(eoiSpecific),
    .eoiLevel   (eoiLevel),
    .inta_n     (inta_n),
    .intOut     (intOut),
    .clrIrr     (clrIrr),
    .isr        (isr),
    .vectorOut  (vectorOut),
    .vectorValid(vectorValid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq = 8'h00; vectorBase = 5'b01000; aeoiMode = 1'b0; rotateOnEoi = 1'b0;
    eoiValid = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0; inta_n = 1'b1;
    #12;
    checks++;
    if ({intOut, clrIrr, isr, vectorOut, vectorValid} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got int=%b clr=%h isr=%h vec=%h vv=%b, want all zero",
               intOut, clrIrr, isr, vectorOut, vectorValid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (intOut !== 1'b0) begin errors++; $display("FAIL reset_idle_int: got %b want 0", intOut); end
  endtask

  task automatic test_basic_ack();
    irq = 8'h04;
    tick();
    checks++;
    if (intOut !== 1'b1) begin errors++; $display("FAIL basic_int: got %b want 1", intOut); end
    inta_n = 1'b0;
    tick();
    checks++;
    if (isr !== 8'h04 || clrIrr !== 8'h04 || intOut !== 1'b0) begin
      errors++;
      $display("FAIL basic_inta1: got isr=%h clr=%h int=%b, want 04 04 0", isr, clrIrr, intOut);
    end
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    checks++;
    if (clrIrr !== 8'h00) begin errors++; $display("FAIL basic_clr_pulse: got %h want 00", clrIrr); end
    inta_n = 1'b0;
    exp_vec.push_back({vectorBase, 3'd2});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); got = vectorValid; end
    exp_v = exp_vec.pop_front();
    checks++;
    if (!got || vectorOut !== exp_v) begin
      errors++;
      $display("FAIL basic_vector: got %h valid=%b, want %h", vectorOut, got, exp_v);
    end
    tick();
    checks++;
    if (vectorValid !== 1'b1 || vectorOut !== 8'h42) begin
      errors++;
      $display("FAIL basic_vector_hold: got %h valid=%b, want 42 1", vectorOut, vectorValid);
    end
    inta_n = 1'b1;
    tick();
    checks++;
    if (vectorValid !== 1'b0 || isr !== 8'h04) begin
      errors++;
      $display("FAIL basic_inta2_rise: got valid=%b isr=%h, want 0 04", vectorValid, isr);
    end
  endtask

  task automatic test_nesting();
    irq = 8'h10;
    tick();
    tick();
    checks++;
    if (intOut !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %b want 0", intOut); end
    irq = 8'h12;
    tick();
    checks++;
    if (intOut !== 1'b1) begin errors++; $display("FAIL nest_preempt: got %b want 1", intOut); end
    inta_n = 1'b0;
    tick();
    checks++;
    if (clrIrr !== 8'h02 || isr !== 8'h06) begin
      errors++;
      $display("FAIL nest_inta1: got clr=%h isr=%h, want 02 06", clrIrr, isr);
    end
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    exp_vec.push_back({vectorBase, 3'd1});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); got = vectorValid; end
    exp_v = exp_vec.pop_front();
    checks++;
    if (!got || vectorOut !== exp_v) begin
      errors++;
      $display("FAIL nest_vector: got %h valid=%b, want %h", vectorOut, got, exp_v);
    end
    inta_n = 1'b1;
    tick();
  endtask

  task automatic test_eoi_rotate();
    rotateOnEoi = 1'b1; eoiSpecific = 1'b0; eoiValid = 1'b1;
    tick();
    eoiValid = 1'b0;
    checks++;
    if (isr !== 8'h04) begin errors++; $display("FAIL eoi_nonspecific: got %h want 04", isr); end
    rotateOnEoi = 1'b0; eoiSpecific = 1'b1; eoiLevel = 3'd2; eoiValid = 1'b1;
    tick();
    eoiValid = 1'b0;
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific: got %h want 00", isr); end
    irq = 8'h06;
    tick();
    inta_n = 1'b0;
    tick();
    checks++;
    if (isr !== 8'h04 || clrIrr !== 8'h04) begin
      errors++;
      $display("FAIL rotated_winner: got isr=%h clr=%h, want 04 04", isr, clrIrr);
    end
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    exp_vec.push_back({vectorBase, 3'd2});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); got = vectorValid; end
    exp_v = exp_vec.pop_front();
    checks++;
    if (!got || vectorOut !== exp_v) begin
      errors++;
      $display("FAIL rotated_vector: got %h valid=%b, want %h", vectorOut, got, exp_v);
    end
    inta_n = 1'b1;
    tick();
    eoiSpecific = 1'b1; eoiLevel = 3'd2; eoiValid = 1'b1;
    tick();
    // Specific EOI on an already-clear bit still rotates: restores IR0-highest.
    rotateOnEoi = 1'b1; eoiLevel = 3'd7;
    tick();
    eoiValid = 1'b0; rotateOnEoi = 1'b0;
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_cleanup: got %h want 00", isr); end
  endtask

  task automatic test_spurious();
    irq = 8'h08;
    tick();
    checks++;
    if (intOut !== 1'b1) begin errors++; $display("FAIL spur_int: got %b want 1", intOut); end
    irq = 8'h00;
    inta_n = 1'b0;
    tick();
    checks++;
    if (isr !== 8'h00 || clrIrr !== 8'h00 || intOut !== 1'b0) begin
      errors++;
      $display("FAIL spur_inta1: got isr=%h clr=%h int=%b, want 00 00 0", isr, clrIrr, intOut);
    end
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    exp_vec.push_back({vectorBase, 3'd7});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); got = vectorValid; end
    exp_v = exp_vec.pop_front();
    checks++;
    if (!got || vectorOut !== exp_v) begin
      errors++;
      $display("FAIL spur_vector: got %h valid=%b, want %h", vectorOut, got, exp_v);
    end
    inta_n = 1'b1;
    tick();
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL spur_isr_after: got %h want 00", isr); end
  endtask

  task automatic test_aeoi();
    aeoiMode = 1'b1;
    irq = 8'h01;
    tick();
    inta_n = 1'b0;
    tick();
    checks++;
    if (isr !== 8'h01) begin errors++; $display("FAIL aeoi_ack1: got %h want 01", isr); end
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    exp_vec.push_back({vectorBase, 3'd0});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); got = vectorValid; end
    exp_v = exp_vec.pop_front();
    checks++;
    if (!got || vectorOut !== exp_v || isr !== 8'h01) begin
      errors++;
      $display("FAIL aeoi_ack2: got vec=%h valid=%b isr=%h, want %h 1 01", vectorOut, got, isr,
               exp_v);
    end
    inta_n = 1'b1;
    tick();
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %h want 00", isr); end
    aeoiMode = 1'b0;
  endtask

  task automatic test_reset_mid();
    irq = 8'h04;
    tick();
    inta_n = 1'b0;
    tick();
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    checks++;
    if (vectorValid !== 1'b1) begin errors++; $display("FAIL mid_in_ack2: got %b want 1", vectorValid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (intOut !== 1'b0 || vectorValid !== 1'b0 || isr !== 8'h00 || clrIrr !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got int=%b vv=%b isr=%h clr=%h, want 0 0 00 00",
               intOut, vectorValid, isr, clrIrr);
    end
    inta_n = 1'b1;
    irq = 8'h81;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (intOut !== 1'b1) begin errors++; $display("FAIL mid_post_int: got %b want 1", intOut); end
    inta_n = 1'b0;
    tick();
    checks++;
    if (clrIrr !== 8'h01 || isr !== 8'h01) begin
      errors++;
      $display("FAIL mid_pointer_reset: got clr=%h isr=%h, want 01 01", clrIrr, isr);
    end
    irq = 8'h00;
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    eoiSpecific = 1'b0; eoiValid = 1'b1;
    tick();
    eoiValid = 1'b0;
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL mid_final_eoi: got %h want 00", isr); end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nesting();
    test_eoi_rotate();
    test_spurious();
    test_aeoi();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
